// File: rtl/car_parking_system.sv
// Parking gate controller: a car at the entrance waits a fixed number of cycles,
// then the gate opens on the correct code and closes again when the car exits.
module car_parking_system #(
    parameter logic [7:0] PASSWORD    = 8'd14,
    parameter int         WAIT_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_entrance,
    input  logic       sensor_exit,
    input  logic [7:0] garage_password,
    output logic       green_led,
    output logic       red_led
);

    // state         | meaning
    // IDLE          | no car at the gate, LEDs off
    // WAIT_PASSWORD | car arrived, giving the driver time to enter the code
    // WRONG_PASS    | code rejected, re-checked every cycle
    // RIGHT_PASS    | gate open until the car passes the exit sensor
    // STOP          | a second car tailgated, gate closed until the code is re-entered
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        STOP          = 3'd4
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic [7:0] count_next;
    logic       pass_ok;

    assign pass_ok = (garage_password == PASSWORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 8'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        green_led  = 1'b0;
        red_led    = 1'b0;
        case (state)
            IDLE: begin
                if (sensor_entrance) begin
                    state_next = WAIT_PASSWORD;
                    count_next = 8'd0;
                end
            end
            WAIT_PASSWORD: begin
                red_led = 1'b1;
                if (count < LAST_WAIT) begin
                    count_next = count + 8'd1;
                end else begin
                    state_next = pass_ok ? RIGHT_PASS : WRONG_PASS;
                end
            end
            WRONG_PASS: begin
                red_led = 1'b1;
                if (pass_ok) state_next = RIGHT_PASS;
            end
            RIGHT_PASS: begin
                green_led = 1'b1;
                // Tailgating has priority over a normal exit.
                if (sensor_entrance && sensor_exit) state_next = STOP;
                else if (sensor_exit)               state_next = IDLE;
            end
            STOP: begin
                red_led = 1'b1;
                if (pass_ok) state_next = RIGHT_PASS;
            end
            default: begin
                state_next = IDLE;
                count_next = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_car_parking_system.sv
// Directed and randomized checks of the parking gate controller LED outputs.
module tb_car_parking_system;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [7:0] garage_password;
    logic       green_led;
    logic       red_led;

    int passed = 0;
    int total  = 0;

    car_parking_system #(.PASSWORD(8'd14), .WAIT_CYCLES(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .garage_password (garage_password),
        .green_led       (green_led),
        .red_led         (red_led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic leds(input string tag, input logic g, input logic r);
        check({tag, "_green"}, green_led, g);
        check({tag, "_red"}, red_led, r);
    endtask

    // reference model state: 0 idle, 1 wait, 2 wrong, 3 right, 4 stop
    int ms;
    int mc;

    initial begin
        rst = 1'b1;
        sensor_entrance = 1'b0;
        sensor_exit = 1'b0;
        garage_password = 8'd0;

        for (int i = 0; i < 5; i++) begin
            sensor_entrance = i[0];
            sensor_exit = ~i[0];
            garage_password = (i % 2 == 0) ? 8'd14 : 8'd13;
            step();
            leds("reset", 1'b0, 1'b0);
        end

        // correct code held from arrival
        rst = 1'b0;
        sensor_entrance = 1'b1;
        sensor_exit = 1'b0;
        garage_password = 8'd14;
        step(); leds("wait_e1", 1'b0, 1'b1);
        step(); leds("wait_e2", 1'b0, 1'b1);
        step(); leds("wait_e3", 1'b0, 1'b1);
        step(); leds("open_e4", 1'b1, 1'b0);

        // normal exit
        sensor_entrance = 1'b0;
        sensor_exit = 1'b1;
        step(); leds("exit_idle", 1'b0, 1'b0);
        sensor_exit = 1'b0;
        step(); leds("idle_hold", 1'b0, 1'b0);

        // wrong code then correct code
        sensor_entrance = 1'b1;
        garage_password = 8'd13;
        step(); step(); step();
        leds("wrong_wait", 1'b0, 1'b1);
        step(); leds("wrong_pass", 1'b0, 1'b1);
        garage_password = 8'd15;
        for (int i = 0; i < 5; i++) begin
            step();
            leds("wrong_hold", 1'b0, 1'b1);
        end
        garage_password = 8'd14;
        step(); leds("wrong_to_right", 1'b1, 1'b0);

        // tailgating, then code re-entered
        garage_password = 8'd13;
        sensor_entrance = 1'b1;
        sensor_exit = 1'b1;
        step(); leds("tailgate_stop", 1'b0, 1'b1);
        sensor_exit = 1'b0;
        step(); leds("stop_hold", 1'b0, 1'b1);
        garage_password = 8'd14;
        step(); leds("stop_to_right", 1'b1, 1'b0);
        sensor_entrance = 1'b0;
        sensor_exit = 1'b1;
        step(); leds("exit_after_stop", 1'b0, 1'b0);

        // entrance dropping during the wait does not abort it
        sensor_exit = 1'b0;
        sensor_entrance = 1'b1;
        garage_password = 8'd0;
        step(); leds("drop_wait", 1'b0, 1'b1);
        sensor_entrance = 1'b0;
        step(); step();
        leds("drop_wait_hold", 1'b0, 1'b1);
        step(); leds("drop_wrong", 1'b0, 1'b1);
        step(); leds("drop_wrong_hold", 1'b0, 1'b1);

        // mid-operation reset overrides a correct code
        rst = 1'b1;
        garage_password = 8'd14;
        step(); leds("mid_reset", 1'b0, 1'b0);
        rst = 1'b0;
        step(); leds("post_reset_idle", 1'b0, 1'b0);

        // random password 13..15 against a reference model, starting from IDLE
        ms = 0;
        mc = 0;
        sensor_exit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sensor_entrance = 1'($urandom_range(0, 1));
            garage_password = 8'($urandom_range(13, 15));
            if (green_led) sensor_exit = 1'b1;
            case (ms)
                0: if (sensor_entrance) begin ms = 1; mc = 0; end
                1: if (mc == 2) ms = (garage_password == 8'd14) ? 3 : 2;
                   else mc = mc + 1;
                2: if (garage_password == 8'd14) ms = 3;
                3: if (sensor_entrance && sensor_exit) ms = 4;
                   else if (sensor_exit) ms = 0;
                4: if (garage_password == 8'd14) ms = 3;
                default: ms = 0;
            endcase
            step();
            check("rand_green", green_led, ms == 3);
            check("rand_red", red_led, (ms == 1) || (ms == 2) || (ms == 4));
            check("rand_exclusive", green_led & red_led, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
